// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one registered WIDTH-bit adder between NREQ
// requesters, with a single backpressured response channel tagged by requester ID.
module adder_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]  rot_s;
  logic             grant_found_s;
  logic [IDW-1:0]   grant_id_s;
  logic [WIDTH-1:0] sel_a_s, sel_b_s;
  logic [WIDTH:0]   sum_s;
  logic             accept_s;

  // Round-robin search: rotate so rr_ptr lands at bit 0, lowest set offset wins
  always_comb begin
    rot_s         = NREQ'({req_valid, req_valid} >> rr_ptr_q);
    grant_found_s = |req_valid;
    grant_id_s    = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      grant_id_s = rot_s[off] ? IDW'((int'(rr_ptr_q) + off) % NREQ) : grant_id_s;
    end
  end

  // Operand select for the winning requester
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s = (grant_id_s == IDW'(i)) ? req_a[i*WIDTH +: WIDTH] : sel_a_s;
      sel_b_s = (grant_id_s == IDW'(i)) ? req_b[i*WIDTH +: WIDTH] : sel_b_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = grant_found_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = rsp_ready ? ST_IDLE : ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; grant is masked during reset so no pair is taken while rst_n is low
  always_comb begin
    busy      = (state_q != ST_IDLE);
    req_ready = '0;
    if ((state_q == ST_IDLE) && grant_found_s && rst_n) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_s;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s = (state_q == ST_IDLE) && grant_found_s;
  assign sum_s    = {1'b0, op_a_q} + {1'b0, op_b_q};

  // Datapath next-state: operand capture on grant, result capture in EXEC
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;
    if (accept_s) begin
      op_a_d   = sel_a_s;
      op_b_d   = sel_b_s;
      op_id_d  = grant_id_s;
      rr_ptr_d = (grant_id_s == IDW'(NREQ - 1)) ? '0 : grant_id_s + IDW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (state_q == ST_EXEC) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = sum_s[WIDTH-1:0];
      rsp_carry_d = sum_s[WIDTH];
      rsp_id_d    = op_id_q;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Datapath and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a cycle model pushes expected results to a scoreboard at
// grant time and pops them at the response handshake; scenario tasks check fixed values.
module tb_adder_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  localparam logic [7:0] OVA [4] = '{8'd128, 8'd255, 8'd100, 8'd0};
  localparam logic [7:0] OVB [4] = '{8'd128, 8'd1,   8'd155, 8'd0};
  localparam logic [7:0] OVS [4] = '{8'd0,   8'd0,   8'd255, 8'd0};
  localparam logic       OVC [4] = '{1'b1,   1'b1,   1'b0,   1'b0};
  localparam logic [3:0] SKV [4] = '{4'b0001, 4'b1001, 4'b1001, 4'b1011};
  localparam int         SKW [4] = '{0, 3, 0, 1};

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_carry;
  logic [IDW-1:0]   rsp_id;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int resp_count = 0;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [IDW-1:0]   id;
  } exp_t;
  exp_t sb[$];
  int m_state = 0;
  int m_ptr = 0;

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Cycle model and scoreboard, sampled on the falling edge
  always @(negedge clk) begin : mon
    int c;
    int w;
    logic fnd;
    logic [WIDTH:0] s;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    if (!rst_n) begin
      checks++;
      if (rsp_valid !== 1'b0 || rsp_sum !== 8'd0 || rsp_carry !== 1'b0 ||
          rsp_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL mon_reset: got v=%b s=%0d c=%b id=%0d busy=%b rdy=%b want all zero",
                 rsp_valid, rsp_sum, rsp_carry, rsp_id, busy, req_ready);
      end
      m_state = 0;
      m_ptr = 0;
      sb.delete();
    end else begin
      checks++;
      if (busy !== (m_state != 0)) begin
        errors++;
        $display("FAIL mon_busy: got %b want %b", busy, (m_state != 0));
      end
      case (m_state)
        0: begin
          fnd = 1'b0;
          w = 0;
          for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (!fnd && req_valid[c]) begin
              fnd = 1'b1;
              w = c;
            end
          end
          exp_rdy = fnd ? (4'b0001 << w) : 4'b0000;
          checks++;
          if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL mon_grant: got %b want %b", req_ready, exp_rdy);
          end
          if (fnd) begin
            s = {1'b0, req_a[w*WIDTH +: WIDTH]} + {1'b0, req_b[w*WIDTH +: WIDTH]};
            e.carry = s[WIDTH];
            e.sum = s[WIDTH-1:0];
            e.id = IDW'(w);
            sb.push_back(e);
            m_ptr = (w + 1) % NREQ;
            m_state = 1;
          end
        end
        1: begin
          checks++;
          if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mon_exec: got v=%b rdy=%b want v=0 rdy=0000", rsp_valid, req_ready);
          end
          m_state = 2;
        end
        default: begin
          checks++;
          if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mon_resp: got v=%b rdy=%b want v=1 rdy=0000", rsp_valid, req_ready);
          end
          if (rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL mon_sb_empty: got response id=%0d want none pending", rsp_id);
            end else begin
              e = sb.pop_front();
              if (rsp_sum !== e.sum || rsp_carry !== e.carry || rsp_id !== e.id) begin
                errors++;
                $display("FAIL mon_rsp_data: got s=%0d c=%b id=%0d want s=%0d c=%b id=%0d",
                         rsp_sum, rsp_carry, rsp_id, e.sum, e.carry, e.id);
              end
            end
            resp_count++;
            m_state = 0;
          end
        end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 8'd0 || rsp_carry !== 1'b0 ||
        rsp_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b s=%0d c=%b id=%0d busy=%b rdy=%b want all zero",
               rsp_valid, rsp_sum, rsp_carry, rsp_id, busy, req_ready);
    end
    cyc();
    cyc();
    req_valid = 4'b0000;
    rst_n = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got v=%b busy=%b rdy=%b want 0 0 0000", rsp_valid, busy, req_ready);
    end
    cyc();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_op(2, 8'd5, 8'd10);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    cyc();
    req_valid = 4'b0000;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_exec: got v=%b busy=%b rdy=%b want 0 1 0000", rsp_valid, busy, req_ready);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'd15 || rsp_carry !== 1'b0 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL single_rsp: got v=%b s=%0d c=%b id=%0d want 1 15 0 2",
               rsp_valid, rsp_sum, rsp_carry, rsp_id);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_overflow();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_op(0, OVA[k], OVB[k]);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL ovf_grant[%0d]: got %b want 0001", k, req_ready);
      end
      cyc();
      req_valid = 4'b0000;
      cyc();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== OVS[k] || rsp_carry !== OVC[k] || rsp_id !== 2'd0) begin
        errors++;
        $display("FAIL ovf_rsp[%0d]: got v=%b s=%0d c=%b id=%0d want 1 %0d %b 0",
                 k, rsp_valid, rsp_sum, rsp_carry, rsp_id, OVS[k], OVC[k]);
      end
      cyc();
    end
  endtask

  task automatic test_all_requesters();
    logic [WIDTH:0] s;
    int w;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i*16 + 3), 8'(i*7 + 200));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = k % NREQ;
      #1;
      checks++;
      if (req_ready !== (4'b0001 << w)) begin
        errors++;
        $display("FAIL all_grant[%0d]: got %b want %b", k, req_ready, 4'b0001 << w);
      end
      cyc();
      cyc();
      s = {1'b0, 8'(w*16 + 3)} + {1'b0, 8'(w*7 + 200)};
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w) || rsp_sum !== s[7:0] || rsp_carry !== s[8]) begin
        errors++;
        $display("FAIL all_rsp[%0d]: got v=%b id=%0d s=%0d c=%b want 1 %0d %0d %b",
                 k, rsp_valid, rsp_id, rsp_sum, rsp_carry, w, s[7:0], s[8]);
      end
      cyc();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    int base;
    rsp_ready = 1'b0;
    set_op(1, 8'd200, 8'd100);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant: got %b want 0010", req_ready);
    end
    cyc();
    req_valid = 4'b1101;
    cyc();
    base = resp_count;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'd44 || rsp_carry !== 1'b1 || rsp_id !== 2'd1 ||
          req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b s=%0d c=%b id=%0d rdy=%b busy=%b want 1 44 1 1 0000 1",
                 i, rsp_valid, rsp_sum, rsp_carry, rsp_id, req_ready, busy);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    req_valid = 4'b0000;
    checks++;
    if (rsp_valid !== 1'b0 || (resp_count - base) !== 1) begin
      errors++;
      $display("FAIL bp_release: got v=%b delivered=%0d want 0 1", rsp_valid, resp_count - base);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b0 || (resp_count - base) !== 1) begin
      errors++;
      $display("FAIL bp_single: got v=%b delivered=%0d want 0 1", rsp_valid, resp_count - base);
    end
  endtask

  task automatic test_rr_skip();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i*10 + 1), 8'(i + 3));
    for (int k = 0; k < 4; k++) begin
      req_valid = SKV[k];
      #1;
      checks++;
      if (req_ready !== (4'b0001 << SKW[k])) begin
        errors++;
        $display("FAIL skip_grant[%0d]: got %b want %b", k, req_ready, 4'b0001 << SKW[k]);
      end
      cyc();
      req_valid = 4'b0000;
      cyc();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(SKW[k])) begin
        errors++;
        $display("FAIL skip_rsp[%0d]: got v=%b id=%0d want 1 %0d", k, rsp_valid, rsp_id, SKW[k]);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    set_op(3, 8'd77, 8'd33);
    set_op(1, 8'd40, 8'd2);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL mid_grant: got %b want 1000", req_ready);
    end
    cyc();
    req_valid = 4'b0000;
    cyc();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 8'd110) begin
      errors++;
      $display("FAIL mid_inflight: got v=%b id=%0d s=%0d want 1 3 110", rsp_valid, rsp_id, rsp_sum);
    end
    rst_n = 1'b0;
    req_valid = 4'b0110;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 8'd0 || rsp_carry !== 1'b0 || rsp_id !== 2'd0 ||
        busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: got v=%b s=%0d c=%b id=%0d busy=%b rdy=%b want all zero",
               rsp_valid, rsp_sum, rsp_carry, rsp_id, busy, req_ready);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_restart: got v=%b rdy=%b want 0 0010", rsp_valid, req_ready);
    end
    cyc();
    req_valid = 4'b0000;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_stale: got v=%b id=%0d want v=0", rsp_valid, rsp_id);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'd42 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL mid_rsp: got v=%b id=%0d s=%0d c=%b want 1 1 42 0",
               rsp_valid, rsp_id, rsp_sum, rsp_carry);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_all_requesters();
    test_backpressure();
    test_rr_skip();
    test_reset_mid();
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares a single registered WIDTH-bit adder between NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake and computes the sum in a dedicated execute cycle. It then presents the sum, the carry-out and the ID of the originating requester on a single response channel with backpressure. It sits between the operand producers and the shared `adder` datapath, so the adder never sees more than one operation in flight.

## Interface
- `WIDTH`, default 8: operand and sum width in bits.
- `NREQ`, default 4: number of requesters; must be ≥2.
- `IDW`, default `$clog2(NREQ)`: requester ID width.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, NREQ: bit i is high when requester i has an operand pair pending.
- `req_ready`, output, NREQ: one-hot grant; bit i high means requester i's pair is taken this cycle.
- `req_a`, input, NREQ*WIDTH: operand A, with requester i at bits [i*WIDTH +: WIDTH].
- `req_b`, input, NREQ*WIDTH: operand B, packed the same way.
- `rsp_valid`, output, 1: response holds a valid result.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_sum`, output, WIDTH: (a+b) mod 2^WIDTH.
- `rsp_carry`, output, 1: bit WIDTH of a+b.
- `rsp_id`, output, IDW: index of the requester the result belongs to.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Combinational round-robin search over `req_valid`, starting at pointer `rr_ptr` and wrapping modulo NREQ.
  - The winner w gets `req_ready[w]=1` in the same cycle; all other ready bits are 0.
  - At the clock edge the block latches `req_a[w]`, `req_b[w]` and w into the operand registers, sets `rr_ptr <= (w+1) mod NREQ`, and moves to EXEC.
  - With no valid request, all ready bits are 0 and the FSM stays in IDLE with `rr_ptr` unchanged.
- EXEC:
  - The adder computes a WIDTH+1-bit sum of the latched operands, zero-extended, with no sign handling.
  - At the edge, `rsp_sum`, `rsp_carry` and `rsp_id` are registered, `rsp_valid` is set to 1, and the FSM moves to RESP.
- RESP:
  - `rsp_valid=1`; `rsp_sum`, `rsp_carry` and `rsp_id` are held stable.
  - On a cycle with `rsp_ready=1`, the handshake completes: `rsp_valid` is cleared at the edge and the FSM returns to IDLE.
  - While `rsp_ready=0`, the FSM stays in RESP indefinitely.
- `req_ready` is always all-zero outside IDLE. A requester that raises `req_valid` must hold it, with stable operands, until it is granted.
- Fairness: a continuously requesting requester is granted within NREQ grants.
- Reset values, asynchronous on `rst_n=0`:
  - State is IDLE, `rr_ptr=0`, and the operand registers are 0.
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_carry=0`, `rsp_id=0`, `busy=0`.
  - `req_ready` is all-zero while `rst_n=0`.
- Reset mid-operation, in EXEC or RESP, discards the in-flight operation with no response. After reset is released, arbitration restarts from requester 0.

## Timing
- Acceptance edge is T0, the IDLE cycle with `req_ready[w]=1`. The FSM is in EXEC during T0+1, and `rsp_valid` is high from T0+2.
- Minimum latency is 2 cycles from grant to `rsp_valid`.
- The next grant can occur one cycle after the `rsp_ready` handshake, since the FSM spends one cycle back in IDLE. Peak throughput is therefore one operation per 3 cycles.
- `req_ready` is a combinational function of `req_valid`, state and `rr_ptr`. It has no combinational path from `rsp_ready`.
- All response outputs come directly from registers.
- Wrap-around: after a grant to NREQ-1, `rr_ptr` returns to 0.

## Test plan
- Reset then a single request: requester 2 sends a=5, b=10 → `req_ready=4'b0100` for 1 cycle, then 2 cycles later `rsp_valid=1`, `rsp_sum=15`, `rsp_carry=0`, `rsp_id=2`.
- Overflow vectors via requester 0:
  - 128+128 → sum=0, carry=1.
  - 255+1 → sum=0, carry=1.
  - 100+155 → sum=255, carry=0.
  - 0+0 → sum=0, carry=0.
- All four requesters held valid from reset with distinct operands → grants in order 0,1,2,3,0, and `rsp_id` follows the same order. Every response sum matches its requester's operands.
- Backpressure: hold `rsp_ready=0` for 5 cycles in RESP → `rsp_valid` and `rsp_sum`/`rsp_carry`/`rsp_id` remain stable, `req_ready` stays all-zero, and `busy=1`. Exactly one response is delivered when `rsp_ready` rises.
- Round-robin skip: `rr_ptr=1` with only requesters 0 and 3 valid → requester 3 is granted first, then 0, then `rr_ptr=1` again.
- Reset mid-operation: assert `rst_n=0` while in RESP with `rsp_valid=1` → all outputs go to 0 immediately. After release, the old result is never presented, and the next grant goes to the lowest-index valid requester.
